// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises I-cache and D-cache line requests onto one memory port,
// preferring D while bounding how long a pending I request can be passed over.
module mem_arbiter #(
  parameter int ADDR_W       = 28,
  parameter int DATA_W       = 128,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              i_clk,
  input  logic              rst_n,
  input  logic              i_mem_read,
  input  logic              i_mem_write,
  input  logic [ADDR_W-1:0] i_mem_addr,
  input  logic [DATA_W-1:0] i_mem_wdata,
  output logic [DATA_W-1:0] i_mem_rdata,
  output logic              i_mem_ready,
  input  logic              d_mem_read,
  input  logic              d_mem_write,
  input  logic [ADDR_W-1:0] d_mem_addr,
  input  logic [DATA_W-1:0] d_mem_wdata,
  output logic [DATA_W-1:0] d_mem_rdata,
  output logic              d_mem_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [1:0]        owner
);
  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, RELEASE} state_t;
  localparam logic [3:0] LIM = 4'(STARVE_LIMIT);
  state_t state_q, state_d;
  logic [3:0] starve_q, starve_d;
  logic rd_q, rd_d, wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  logic i_rdy_q, i_rdy_d, d_rdy_q, d_rdy_d;
  logic i_req, d_req, pick_i;
  always_comb begin
    i_req = i_mem_read | i_mem_write;
    d_req = d_mem_read | d_mem_write;
    pick_i = i_req & (~d_req | (starve_q == LIM));
    state_d = state_q;
    starve_d = starve_q;
    rd_d = rd_q;
    wr_d = wr_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    i_rdy_d = 1'b0;
    d_rdy_d = 1'b0;
    case (state_q)
      IDLE: if (i_req | d_req) begin
        state_d = pick_i ? GRANT_I : GRANT_D;
        wr_d = pick_i ? i_mem_write : d_mem_write;
        rd_d = pick_i ? i_mem_read & ~i_mem_write : d_mem_read & ~d_mem_write;
        addr_d = pick_i ? i_mem_addr : d_mem_addr;
        wdata_d = pick_i ? i_mem_wdata : d_mem_wdata;
        starve_d = pick_i ? 4'd0 : (i_req && starve_q != LIM) ? starve_q + 4'd1 : starve_q;
      end
      GRANT_I, GRANT_D: if (mem_ready) begin
        state_d = RELEASE;
        rd_d = 1'b0;
        wr_d = 1'b0;
        i_rdy_d = state_q == GRANT_I;
        d_rdy_d = state_q == GRANT_D;
        i_rdata_d = (rd_q && state_q == GRANT_I) ? mem_rdata : i_rdata_q;
        d_rdata_d = (rd_q && state_q == GRANT_D) ? mem_rdata : d_rdata_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      starve_q <= '0;
      rd_q <= 1'b0;
      wr_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      i_rdy_q <= 1'b0;
      d_rdy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      starve_q <= starve_d;
      rd_q <= rd_d;
      wr_q <= wr_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      i_rdy_q <= i_rdy_d;
      d_rdy_q <= d_rdy_d;
    end
  end
  assign mem_read = rd_q;
  assign mem_write = wr_q;
  assign mem_addr = (rd_q | wr_q) ? addr_q : '0;
  assign mem_wdata = wr_q ? wdata_q : '0;
  assign i_mem_rdata = i_rdata_q;
  assign d_mem_rdata = d_rdata_q;
  assign i_mem_ready = i_rdy_q;
  assign d_mem_ready = d_rdy_q;
  assign owner = state_q == GRANT_I ? 2'b01 : state_q == GRANT_D ? 2'b10 : 2'b00;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios for mem_arbiter with hand-computed expectations.
module tb_mem_arbiter;
  logic         i_clk = 1'b0;
  logic         rst_n;
  logic         i_mem_read, i_mem_write, d_mem_read, d_mem_write, mem_ready;
  logic [27:0]  i_mem_addr, d_mem_addr, mem_addr;
  logic [127:0] i_mem_wdata, d_mem_wdata, i_mem_rdata, d_mem_rdata, mem_wdata, mem_rdata;
  logic         i_mem_ready, d_mem_ready, mem_read, mem_write;
  logic [1:0]   owner;
  int vectors = 0;
  int errors = 0;
  localparam logic [127:0] RD_A5 = 128'h0123_4567_89AB_CDEF_0011_2233_4455_66A5;
  localparam logic [127:0] WD_D  = 128'hDEAD_BEEF_CAFE_F00D_1357_9BDF_2468_ACE0;
  localparam logic [127:0] RD_I2 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
  localparam logic [127:0] RD_D3 = 128'h9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0001;
  localparam logic [127:0] WD_V  = 128'h0F0F_0F0F_A5A5_5A5A_C3C3_3C3C_1234_5678;

  mem_arbiter #(.ADDR_W(28), .DATA_W(128), .STARVE_LIMIT(4)) dut (
    .i_clk(i_clk), .rst_n(rst_n),
    .i_mem_read(i_mem_read), .i_mem_write(i_mem_write), .i_mem_addr(i_mem_addr),
    .i_mem_wdata(i_mem_wdata), .i_mem_rdata(i_mem_rdata), .i_mem_ready(i_mem_ready),
    .d_mem_read(d_mem_read), .d_mem_write(d_mem_write), .d_mem_addr(d_mem_addr),
    .d_mem_wdata(d_mem_wdata), .d_mem_rdata(d_mem_rdata), .d_mem_ready(d_mem_ready),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .owner(owner)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    {i_mem_read, i_mem_write, d_mem_read, d_mem_write, mem_ready} = '0;
    i_mem_addr = '0; d_mem_addr = '0; i_mem_wdata = '0; d_mem_wdata = '0; mem_rdata = '0;
    tick(); tick();
    vectors++;
    if ({mem_read, mem_write, i_mem_ready, d_mem_ready, owner} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl got %b want 000000", {mem_read, mem_write, i_mem_ready, d_mem_ready, owner});
    end
    vectors++;
    if (mem_addr !== 28'h0 || mem_wdata !== '0 || i_mem_rdata !== '0 || d_mem_rdata !== '0) begin
      errors++; $display("FAIL reset_data addr %h wdata %h irdata %h drdata %h want all 0", mem_addr, mem_wdata, i_mem_rdata, d_mem_rdata);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_i_read();
    i_mem_read = 1'b1; i_mem_addr = 28'h0000010;
    tick();
    vectors++;
    if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_addr !== 28'h0000010 || owner !== 2'b01) begin
      errors++; $display("FAIL i_read_grant rd %b wr %b addr %h owner %b want 1 0 0000010 01", mem_read, mem_write, mem_addr, owner);
    end
    for (int k = 0; k < 4; k++) tick();
    vectors++;
    if (i_mem_ready !== 1'b0 || mem_read !== 1'b1) begin
      errors++; $display("FAIL i_read_wait ready %b rd %b want 0 1", i_mem_ready, mem_read);
    end
    mem_ready = 1'b1; mem_rdata = RD_A5;
    tick();
    vectors++;
    if (i_mem_ready !== 1'b1 || i_mem_rdata !== RD_A5 || d_mem_ready !== 1'b0 || mem_read !== 1'b0 || owner !== 2'b00) begin
      errors++; $display("FAIL i_read_done irdy %b rdata %h drdy %b rd %b owner %b want 1 %h 0 0 00", i_mem_ready, i_mem_rdata, d_mem_ready, mem_read, owner, RD_A5);
    end
    i_mem_read = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
    tick();
    vectors++;
    if (i_mem_ready !== 1'b0 || d_mem_ready !== 1'b0 || i_mem_rdata !== RD_A5 || owner !== 2'b00) begin
      errors++; $display("FAIL i_read_pulse irdy %b drdy %b rdata %h owner %b want 0 0 %h 00", i_mem_ready, d_mem_ready, i_mem_rdata, owner, RD_A5);
    end
  endtask

  task automatic test_both();
    i_mem_read = 1'b1; i_mem_addr = 28'h0000020;
    d_mem_write = 1'b1; d_mem_addr = 28'h0000030; d_mem_wdata = WD_D;
    tick();
    vectors++;
    if (owner !== 2'b10 || mem_write !== 1'b1 || mem_read !== 1'b0 || mem_wdata !== WD_D || mem_addr !== 28'h0000030) begin
      errors++; $display("FAIL both_d_first owner %b wr %b rd %b wdata %h addr %h want 10 1 0 %h 0000030", owner, mem_write, mem_read, mem_wdata, mem_addr, WD_D);
    end
    mem_ready = 1'b1;
    tick();
    vectors++;
    if (d_mem_ready !== 1'b1 || i_mem_ready !== 1'b0 || owner !== 2'b00 || mem_write !== 1'b0) begin
      errors++; $display("FAIL both_d_done drdy %b irdy %b owner %b wr %b want 1 0 00 0", d_mem_ready, i_mem_ready, owner, mem_write);
    end
    d_mem_write = 1'b0; mem_ready = 1'b0;
    tick();
    vectors++;
    if (owner !== 2'b00 || d_mem_ready !== 1'b0 || mem_read !== 1'b0) begin
      errors++; $display("FAIL both_idle owner %b drdy %b rd %b want 00 0 0", owner, d_mem_ready, mem_read);
    end
    tick();
    vectors++;
    if (owner !== 2'b01 || mem_read !== 1'b1 || mem_addr !== 28'h0000020 || mem_wdata !== '0) begin
      errors++; $display("FAIL both_i_second owner %b rd %b addr %h wdata %h want 01 1 0000020 0", owner, mem_read, mem_addr, mem_wdata);
    end
    mem_ready = 1'b1; mem_rdata = RD_I2;
    tick();
    vectors++;
    if (i_mem_ready !== 1'b1 || i_mem_rdata !== RD_I2 || d_mem_rdata !== '0) begin
      errors++; $display("FAIL both_i_done irdy %b irdata %h drdata %h want 1 %h 0", i_mem_ready, i_mem_rdata, d_mem_rdata, RD_I2);
    end
    i_mem_read = 1'b0; mem_ready = 1'b0;
    tick();
  endtask

  task automatic test_starve();
    logic [1:0] exp;
    i_mem_read = 1'b1; i_mem_addr = 28'h00000A0;
    d_mem_read = 1'b1; d_mem_addr = 28'h00000B0;
    for (int k = 0; k < 10; k++) begin
      exp = (k % 5 == 4) ? 2'b01 : 2'b10;
      tick();
      vectors++;
      if (owner !== exp) begin
        errors++; $display("FAIL starve_grant%0d owner %b want %b", k, owner, exp);
      end
      mem_ready = 1'b1;
      tick();
      vectors++;
      if ({i_mem_ready, d_mem_ready} !== {exp[0], exp[1]}) begin
        errors++; $display("FAIL starve_ready%0d irdy/drdy %b want %b", k, {i_mem_ready, d_mem_ready}, {exp[0], exp[1]});
      end
      mem_ready = 1'b0;
      if (k == 9) begin i_mem_read = 1'b0; d_mem_read = 1'b0; end
      tick();
    end
  endtask

  task automatic test_hold();
    d_mem_read = 1'b1; d_mem_addr = 28'h0000040;
    tick();
    d_mem_addr = 28'h0000050; i_mem_read = 1'b1; i_mem_addr = 28'h0000060;
    tick(); tick();
    vectors++;
    if (owner !== 2'b10 || mem_read !== 1'b1 || mem_addr !== 28'h0000040) begin
      errors++; $display("FAIL hold_addr owner %b rd %b addr %h want 10 1 0000040", owner, mem_read, mem_addr);
    end
    mem_ready = 1'b1; mem_rdata = RD_D3;
    tick();
    vectors++;
    if (d_mem_ready !== 1'b1 || d_mem_rdata !== RD_D3 || i_mem_ready !== 1'b0) begin
      errors++; $display("FAIL hold_d_done drdy %b drdata %h irdy %b want 1 %h 0", d_mem_ready, d_mem_rdata, i_mem_ready, RD_D3);
    end
    d_mem_read = 1'b0; mem_ready = 1'b0;
    tick(); tick();
    vectors++;
    if (owner !== 2'b01 || mem_addr !== 28'h0000060) begin
      errors++; $display("FAIL hold_i_next owner %b addr %h want 01 0000060", owner, mem_addr);
    end
    mem_ready = 1'b1;
    tick();
    i_mem_read = 1'b0; mem_ready = 1'b0;
    tick(); tick();
  endtask

  task automatic test_reset_mid();
    d_mem_read = 1'b1; d_mem_addr = 28'h0000070;
    tick();
    vectors++;
    if (owner !== 2'b10 || mem_read !== 1'b1) begin
      errors++; $display("FAIL rmid_grant owner %b rd %b want 10 1", owner, mem_read);
    end
    rst_n = 1'b0; d_mem_read = 1'b0;
    tick();
    vectors++;
    if ({mem_read, mem_write, i_mem_ready, d_mem_ready, owner} !== 6'b0 || mem_addr !== 28'h0 || d_mem_rdata !== '0) begin
      errors++; $display("FAIL rmid_cleared ctrl %b addr %h drdata %h want 0", {mem_read, mem_write, i_mem_ready, d_mem_ready, owner}, mem_addr, d_mem_rdata);
    end
    rst_n = 1'b1; mem_ready = 1'b1;
    tick();
    vectors++;
    if (d_mem_ready !== 1'b0 || i_mem_ready !== 1'b0 || owner !== 2'b00) begin
      errors++; $display("FAIL rmid_no_pulse drdy %b irdy %b owner %b want 0 0 00", d_mem_ready, i_mem_ready, owner);
    end
    mem_ready = 1'b0; i_mem_read = 1'b1; i_mem_addr = 28'h0000080;
    tick();
    vectors++;
    if (owner !== 2'b01 || mem_read !== 1'b1 || mem_addr !== 28'h0000080) begin
      errors++; $display("FAIL rmid_new owner %b rd %b addr %h want 01 1 0000080", owner, mem_read, mem_addr);
    end
    mem_ready = 1'b1; mem_rdata = RD_A5;
    tick();
    vectors++;
    if (i_mem_ready !== 1'b1 || i_mem_rdata !== RD_A5) begin
      errors++; $display("FAIL rmid_new_done irdy %b rdata %h want 1 %h", i_mem_ready, i_mem_rdata, RD_A5);
    end
    i_mem_read = 1'b0; mem_ready = 1'b0;
    tick(); tick();
  endtask

  task automatic test_spurious_dual();
    mem_ready = 1'b1; mem_rdata = RD_I2;
    tick(); tick();
    vectors++;
    if (i_mem_ready !== 1'b0 || d_mem_ready !== 1'b0 || owner !== 2'b00 || i_mem_rdata !== RD_A5) begin
      errors++; $display("FAIL spurious irdy %b drdy %b owner %b irdata %h want 0 0 00 %h", i_mem_ready, d_mem_ready, owner, i_mem_rdata, RD_A5);
    end
    mem_ready = 1'b0;
    d_mem_read = 1'b1; d_mem_write = 1'b1; d_mem_addr = 28'h0000090; d_mem_wdata = WD_V;
    tick();
    vectors++;
    if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_wdata !== WD_V || mem_addr !== 28'h0000090) begin
      errors++; $display("FAIL dual_cmd wr %b rd %b wdata %h addr %h want 1 0 %h 0000090", mem_write, mem_read, mem_wdata, mem_addr, WD_V);
    end
    mem_ready = 1'b1;
    tick();
    vectors++;
    if (d_mem_ready !== 1'b1 || d_mem_rdata !== '0 || mem_write !== 1'b0) begin
      errors++; $display("FAIL dual_done drdy %b drdata %h wr %b want 1 0 0", d_mem_ready, d_mem_rdata, mem_write);
    end
    d_mem_read = 1'b0; d_mem_write = 1'b0; mem_ready = 1'b0;
    tick(); tick();
  endtask

  initial begin
    test_reset();
    test_i_read();
    test_both();
    test_starve();
    test_hold();
    test_reset_mid();
    test_spurious_dual();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
